debug_unlock_ctrl: RTL
======================

Name: debug_unlock_ctrl

Overview:
- Authentication stage that produces the debug_unlocked qualifier consumed by the downstream lockable configuration registers.
- A debug host streams a multi-word key over a valid/ready interface; a full-width compare grants a time-limited unlock session.
- Failed attempts cause a fixed back-off; MAX_FAIL failures cause a sticky lockout that clears only on reset.

Parameters:
- KEY_WORDS, 4: number of 16-bit key words per attempt (>=1).
- UNLOCK_KEY, 64'hA5A5_1234_C0DE_F00D: expected key, width 16*KEY_WORDS; word 0 is the MS word.
- MAX_FAIL, 3: failed attempts before permanent lockout (>=1).
- BACKOFF_CYC, 16: cycles in BACKOFF after a failed attempt (>=1).
- SESSION_CYC, 1024: unlock session length in cycles; 0 = no timeout.

Ports:
- Clk, input, 1: single clock; all state updates on the rising edge.
- resetn, input, 1: asynchronous active-low reset.
- key_valid, input, 1: key word present.
- key_word, input, 16: key data.
- key_ready, output, 1: word accepted when key_valid & key_ready.
- dbg_exit, input, 1: host request to end the session or abort collection.
- scan_mode, input, 1: scan indication; used only with the optional feature.
- debug_unlocked, output, 1: unlock qualifier for downstream registers.
- auth_fail, output, 1: one-cycle pulse per failed attempt.
- lockout, output, 1: sticky lockout flag.
- fail_count, output, $clog2(MAX_FAIL+1): failed attempts since the last success; saturates at MAX_FAIL.

Behaviour:
- Reset state: IDLE; key shift register = 0; word index = 0; counters = 0; all outputs 0.
- Reset during any state, including mid-collection, discards the partial key.
- States: IDLE, COLLECT, CHECK, UNLOCKED, BACKOFF, LOCKOUT. All outputs are registered unless stated otherwise.
- key_ready is combinational: 1 in IDLE and COLLECT, 0 in all other states.
- IDLE, on an accepted word: shift the word in and set index = 1. Go to COLLECT, or directly to CHECK if KEY_WORDS == 1.
- COLLECT:
  - Each accepted word shifts in (left shift by 16) and increments the index.
  - On the KEY_WORDS-th word, go to CHECK.
  - dbg_exit (priority over key_valid): abort to IDLE, clear the shift register and index; no failure is counted.
- CHECK (exactly one cycle): compare all 16*KEY_WORDS bits at once; no early exit on the first mismatching word.
  - Match: go to UNLOCKED, fail_count = 0, clear the shift register.
  - Mismatch: fail_count += 1 and auth_fail pulses for one cycle, coincident with the first cycle of the next state. Clear the shift register. Go to LOCKOUT if the new fail_count == MAX_FAIL, otherwise go to BACKOFF.
- Latency: last word accepted at edge N; CHECK occupies cycle N..N+1; debug_unlocked = 1 after edge N+2.
- UNLOCKED:
  - debug_unlocked = 1 and the session counter increments each cycle.
  - Exit to IDLE on dbg_exit, or when the counter reaches SESSION_CYC-1 (SESSION_CYC != 0).
  - debug_unlocked falls at the exit edge; the counter clears.
- BACKOFF: key_valid is ignored (words are dropped, not queued). Stay BACKOFF_CYC cycles, then go to IDLE.
- LOCKOUT: lockout = 1, key_ready = 0. dbg_exit and key_valid are ignored. Only resetn leaves this state.
- fail_count is not cleared by dbg_exit, BACKOFF expiry or session timeout; only a successful CHECK or reset clears it.
- Simultaneous dbg_exit and session expiry in the same cycle: a single exit to IDLE.

Optional Feature:
- Macro: DBG_UNLOCK_SCAN_GUARD_EN.
- Defined:
  - scan_mode = 1 forces key_ready = 0.
  - debug_unlocked = register & ~scan_mode (combinational gate, so it is low in the same cycle scan_mode rises).
  - From COLLECT, CHECK or UNLOCKED, go to IDLE at the next edge: shift register cleared, no failure counted, no auth_fail pulse.
  - BACKOFF and LOCKOUT are unaffected.
- Undefined: scan_mode is ignored entirely; scan cannot alter the unlock state.

Test Plan:
- Correct key: reset, then send A5A5,1234,C0DE,F00D back-to-back -> debug_unlocked = 1 two edges after the 4th accept; fail_count = 0.
- Session timeout: unlock with SESSION_CYC = 1024 -> debug_unlocked falls after 1024 cycles in UNLOCKED; state IDLE; key_ready = 1.
- Wrong key and back-off: send A5A5,1234,C0DE,F00E -> auth_fail pulses once; fail_count = 1; key_ready = 0 for 16 cycles; words sent in BACKOFF are dropped; then IDLE.
- Lockout: three wrong keys -> fail_count = 3 and lockout = 1. A correct key is then not accepted (key_ready = 0). resetn low -> all outputs 0.
- Abort and exit: dbg_exit after 2 words -> IDLE with fail_count unchanged, and a subsequent correct key unlocks. dbg_exit while UNLOCKED -> debug_unlocked = 0 at the next edge.
- With DBG_UNLOCK_SCAN_GUARD_EN: scan_mode = 1 while UNLOCKED -> debug_unlocked = 0 in the same cycle, state IDLE next edge, fail_count unchanged. Without the macro: debug_unlocked stays 1.

Source files
------------

// File: rtl/debug_unlock_ctrl.sv
// debug_unlock_ctrl: key-authenticated, time-limited debug unlock with back-off and sticky lockout.
// Optional scan guard: define DBG_UNLOCK_SCAN_GUARD_EN.
module debug_unlock_ctrl #(
  parameter int KEY_WORDS = 4,
  parameter logic [16*KEY_WORDS-1:0] UNLOCK_KEY = 64'hA5A5_1234_C0DE_F00D,
  parameter int MAX_FAIL = 3,
  parameter int BACKOFF_CYC = 16,
  parameter int SESSION_CYC = 1024
) (
  input  logic Clk,
  input  logic resetn,
  input  logic key_valid,
  input  logic [15:0] key_word,
  output logic key_ready,
  input  logic dbg_exit,
  input  logic scan_mode,
  output logic debug_unlocked,
  output logic auth_fail,
  output logic lockout,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_count
);
  localparam int W = 16 * KEY_WORDS;
  localparam int IW = $clog2(KEY_WORDS + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int SW = SESSION_CYC > 1 ? $clog2(SESSION_CYC) : 1;
  localparam int BW = BACKOFF_CYC > 1 ? $clog2(BACKOFF_CYC) : 1;
  typedef enum logic [2:0] {IDLE, COLLECT, CHECK, UNLOCKED, BACKOFF, LOCKOUT} state_t;
  state_t state, nxt;
  logic [W-1:0] key_sr;
  logic [IW-1:0] idx;
  logic [SW-1:0] sess_cnt;
  logic [BW-1:0] back_cnt;
  logic [FW-1:0] fail_nxt;
  logic du_q, scan, accept, last, match, sess_done, back_done, chk_fail, stay_unl;
`ifdef DBG_UNLOCK_SCAN_GUARD_EN
  assign scan = scan_mode;
`else
  logic unused_scan;
  assign scan = 1'b0;
  assign unused_scan = scan_mode;
`endif
  assign key_ready = (state == IDLE || state == COLLECT) & ~scan & resetn;
  assign accept = key_valid & key_ready;
  assign last = idx == IW'(KEY_WORDS - 1);
  assign match = key_sr == UNLOCK_KEY;
  assign sess_done = SESSION_CYC != 0 && sess_cnt == SW'(SESSION_CYC - 1);
  assign back_done = back_cnt == BW'(BACKOFF_CYC - 1);
  assign fail_nxt = fail_count == FW'(MAX_FAIL) ? fail_count : FW'(fail_count + 1'b1);
  assign chk_fail = state == CHECK && !match && !scan;
  assign stay_unl = state == UNLOCKED && nxt == UNLOCKED;
  assign debug_unlocked = du_q & ~scan;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (accept) nxt = KEY_WORDS == 1 ? CHECK : COLLECT;
      COLLECT:  if (dbg_exit) nxt = IDLE; else if (accept && last) nxt = CHECK;
      CHECK:    nxt = match ? UNLOCKED : (fail_nxt == FW'(MAX_FAIL) ? LOCKOUT : BACKOFF);
      UNLOCKED: if (dbg_exit || sess_done) nxt = IDLE;
      BACKOFF:  if (back_done) nxt = IDLE;
      LOCKOUT:  nxt = LOCKOUT;
      default:  nxt = IDLE;
    endcase
    if (scan && (state == COLLECT || state == CHECK || state == UNLOCKED)) nxt = IDLE;
  end
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      key_sr <= '0;
      idx <= '0;
      sess_cnt <= '0;
      back_cnt <= '0;
      fail_count <= '0;
      du_q <= 1'b0;
      auth_fail <= 1'b0;
      lockout <= 1'b0;
    end else begin
      state <= nxt;
      auth_fail <= chk_fail;
      lockout <= nxt == LOCKOUT;
      du_q <= stay_unl;
      sess_cnt <= stay_unl ? SW'(sess_cnt + 1'b1) : '0;
      back_cnt <= (state == BACKOFF && nxt == BACKOFF) ? BW'(back_cnt + 1'b1) : '0;
      if (state == CHECK && !scan) fail_count <= match ? '0 : fail_nxt;
      // Partial keys never survive a return to IDLE or a compare.
      if (state == CHECK || nxt == IDLE) begin
        key_sr <= '0;
        idx <= '0;
      end else if (accept) begin
        key_sr <= W'({key_sr, key_word});
        idx <= IW'(idx + 1'b1);
      end
    end
  end
endmodule
